dec_select_ctrl: RTL and testbench

Sequencing controller for the decryption subsystem. It accepts a per-message command naming the target decryptor (0 Caesar, 1 Scytale, 2 ZigZag). It then forwards the encrypted character stream to that decryptor only, and drives the output mux `select` until that decryptor has drained. The block sits between the system input and the three decryptors, and owns the mux `select` line. Only one message is in flight at a time.

---
 rtl/dec_pkg.sv | 19 +
 rtl/dec_select_ctrl_if.sv | 21 ++
 rtl/dec_drain_timer.sv | 40 ++++
 rtl/dec_select_ctrl.sv | 130 +++++++++++++
 tb/tb_dec_select_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dec_pkg.sv
// Shared types and encodings for the decryption select controller.
// Imported by dec_select_ctrl and dec_drain_timer.
package dec_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DRAIN,
      ST_DONE
   } state_t;

   localparam logic [1:0] SEL_CAESAR  = 2'd0;
   localparam logic [1:0] SEL_SCYTALE = 2'd1;
   localparam logic [1:0] SEL_ZIGZAG  = 2'd2;
   localparam logic [1:0] SEL_NONE    = 2'd3;

   localparam logic [7:0] DEF_END_CHAR = 8'hFA;

endpackage

// File: rtl/dec_select_ctrl_if.sv
// Command handshake between the system and the select controller.
// master issues cmd_sel/cmd_valid, slave answers with cmd_ready.
interface dec_select_ctrl_if;

   logic [1:0] cmd_sel;
   logic       cmd_valid;
   logic       cmd_ready;

   modport master (
      output cmd_sel,
      output cmd_valid,
      input  cmd_ready
   );

   modport slave (
      input  cmd_sel,
      input  cmd_valid,
      output cmd_ready
   );

endinterface

// File: rtl/dec_drain_timer.sv
// Counts cycles spent in DRAIN; flags minimum drain time and timeout.
// Timeout compare is built only when DEC_CTRL_TIMEOUT_EN is defined.
module dec_drain_timer
   import dec_pkg::*;
#(
   parameter int MIN_DRAIN = 2,
   parameter int TIMEOUT   = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic min_ok,
   output logic tmo
);

   localparam int MIN_LAST_I = (MIN_DRAIN > 0) ? MIN_DRAIN - 1 : 0;
   localparam logic [15:0] MIN_LAST = 16'(MIN_LAST_I);
   localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

`ifdef DEC_CTRL_TIMEOUT_EN
   localparam logic TMO_EN = 1'b1;
`else
   localparam logic TMO_EN = 1'b0;
`endif

   logic [15:0] drain_cnt;

   // Cleared outside DRAIN so it starts at 0 on entry; saturates.
   always_ff @(posedge clk) begin
      if (!rst_n || !run) begin
         drain_cnt <= '0;
      end else if (drain_cnt != 16'hFFFF) begin
         drain_cnt <= drain_cnt + 16'd1;
      end
   end

   assign min_ok = run && (drain_cnt >= MIN_LAST);
   assign tmo    = TMO_EN && run && (drain_cnt == TO_LAST);

endmodule

// File: rtl/dec_select_ctrl.sv
// Routes one message at a time to the chosen decryptor and owns the
// output mux select. Optional DRAIN timeout: DEC_CTRL_TIMEOUT_EN.
module dec_select_ctrl
   import dec_pkg::*;
#(
   parameter int                 D_WIDTH   = 8,
   parameter logic [D_WIDTH-1:0] END_CHAR  = D_WIDTH'(DEF_END_CHAR),
   parameter int                 MIN_DRAIN = 2,
   parameter int                 TIMEOUT   = 1024
) (
   input  logic               clk,
   input  logic               rst_n,
   dec_select_ctrl_if.slave   cmd,
   input  logic [D_WIDTH-1:0] data_i,
   input  logic               valid_i,
   output logic [D_WIDTH-1:0] data_o,
   output logic               valid0_o,
   output logic               valid1_o,
   output logic               valid2_o,
   input  logic               busy0_i,
   input  logic               busy1_i,
   input  logic               busy2_i,
   output logic [1:0]         select_o,
   output logic               done_o,
   output logic               err_o
);

   state_t     state;
   logic [1:0] sel_q;
   logic       ready_q;
   logic       busy_sel;
   logic       min_ok;
   logic       tmo;

   assign cmd.cmd_ready = ready_q;

   // Only the selected decryptor's busy matters.
   always_comb begin
      busy_sel = 1'b0;
      case (sel_q)
         SEL_CAESAR:  busy_sel = busy0_i;
         SEL_SCYTALE: busy_sel = busy1_i;
         SEL_ZIGZAG:  busy_sel = busy2_i;
         default:     busy_sel = 1'b0;
      endcase
   end

   dec_drain_timer #(
      .MIN_DRAIN (MIN_DRAIN),
      .TIMEOUT   (TIMEOUT)
   ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .run    (state == ST_DRAIN),
      .min_ok (min_ok),
      .tmo    (tmo)
   );

   // Message sequencer with all outputs registered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         sel_q    <= SEL_NONE;
         ready_q  <= 1'b1;
         data_o   <= '0;
         valid0_o <= 1'b0;
         valid1_o <= 1'b0;
         valid2_o <= 1'b0;
         select_o <= SEL_NONE;
         done_o   <= 1'b0;
         err_o    <= 1'b0;
      end else begin
         valid0_o <= 1'b0;
         valid1_o <= 1'b0;
         valid2_o <= 1'b0;
         done_o   <= 1'b0;
         err_o    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cmd.cmd_valid) begin
                  if (cmd.cmd_sel != SEL_NONE) begin
                     sel_q    <= cmd.cmd_sel;
                     select_o <= cmd.cmd_sel;
                     ready_q  <= 1'b0;
                     state    <= ST_LOAD;
                  end else begin
                     err_o <= 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               if (valid_i) begin
                  data_o <= data_i;
                  case (sel_q)
                     SEL_CAESAR:  valid0_o <= 1'b1;
                     SEL_SCYTALE: valid1_o <= 1'b1;
                     SEL_ZIGZAG:  valid2_o <= 1'b1;
                     default:     ;
                  endcase
                  if (data_i == END_CHAR) begin
                     state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (min_ok && !busy_sel) begin
                  done_o <= 1'b1;
                  state  <= ST_DONE;
               end else if (tmo && busy_sel) begin
                  err_o    <= 1'b1;
                  select_o <= SEL_NONE;
                  ready_q  <= 1'b1;
                  state    <= ST_IDLE;
               end
            end
            ST_DONE: begin
               select_o <= SEL_NONE;
               ready_q  <= 1'b1;
               state    <= ST_IDLE;
            end
            default: begin
               select_o <= SEL_NONE;
               ready_q  <= 1'b1;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dec_select_ctrl.sv
// Self-checking bench for dec_select_ctrl with a message-level model.
// Timeout scenario is exercised when DEC_CTRL_TIMEOUT_EN is defined.
module tb_dec_select_ctrl;
   import dec_pkg::*;

   localparam int MIN_DRAIN = 2;
   localparam int TIMEOUT   = 16;
   localparam logic [7:0] ENDC = 8'hFA;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] data_i = '0;
   logic       valid_i = 1'b0;
   logic [7:0] data_o;
   logic       valid0_o, valid1_o, valid2_o;
   logic [2:0] busy = '0;
   logic [1:0] select_o;
   logic       done_o, err_o;

   int npass = 0;
   int nfail = 0;
   int ntotal = 0;

   logic [8:0] beats[$];

   always #5 clk = ~clk;

   dec_select_ctrl_if cmd_if ();

   dec_select_ctrl #(
      .D_WIDTH   (8),
      .END_CHAR  (ENDC),
      .MIN_DRAIN (MIN_DRAIN),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cmd      (cmd_if),
      .data_i   (data_i),
      .valid_i  (valid_i),
      .data_o   (data_o),
      .valid0_o (valid0_o),
      .valid1_o (valid1_o),
      .valid2_o (valid2_o),
      .busy0_i  (busy[0]),
      .busy1_i  (busy[1]),
      .busy2_i  (busy[2]),
      .select_o (select_o),
      .done_o   (done_o),
      .err_o    (err_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [31:0] strobes();
      return 32'({valid2_o, valid1_o, valid0_o});
   endfunction

   // Plays the beats queue as one message, then models DRAIN/DONE.
   task automatic run_msg(input logic [1:0] sel, input int b);
      int k0;
      bit tmo_exit;
      logic [2:0] ev;
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_sel   = sel;
      cyc();
      chk("acc_select", 32'(select_o), 32'(sel));
      chk("acc_ready", 32'(cmd_if.cmd_ready), 0);
      foreach (beats[i]) begin
         cmd_if.cmd_valid = 1'($urandom_range(0, 1));
         cmd_if.cmd_sel   = 2'($urandom_range(0, 3));
         busy    = 3'($urandom_range(0, 7));
         valid_i = beats[i][8];
         data_i  = beats[i][7:0];
         cyc();
         ev = beats[i][8] ? (3'b001 << sel) : 3'b000;
         chk("load_strobe", strobes(), 32'(ev));
         if (beats[i][8]) chk("load_data", 32'(data_o), 32'(beats[i][7:0]));
         chk("load_select", 32'(select_o), 32'(sel));
      end
      cmd_if.cmd_valid = 1'b0;
      k0 = (b > MIN_DRAIN - 1) ? b : MIN_DRAIN - 1;
      tmo_exit = 1'b0;
`ifdef DEC_CTRL_TIMEOUT_EN
      if (k0 > TIMEOUT - 1) begin
         k0 = TIMEOUT - 1;
         tmo_exit = 1'b1;
      end
`endif
      for (int k = 0; k <= k0; k++) begin
         busy      = 3'($urandom_range(0, 7));
         busy[sel] = (k < b);
         valid_i   = 1'($urandom_range(0, 1));
         data_i    = 8'($urandom_range(0, 255));
         cmd_if.cmd_valid = 1'($urandom_range(0, 1));
         cmd_if.cmd_sel   = 2'($urandom_range(0, 3));
         cyc();
         chk("drain_strobe", strobes(), 0);
         if (k < k0) begin
            chk("drain_done", 32'(done_o), 0);
            chk("drain_select", 32'(select_o), 32'(sel));
         end else if (tmo_exit) begin
            chk("tmo_err", 32'(err_o), 1);
            chk("tmo_done", 32'(done_o), 0);
            chk("tmo_select", 32'(select_o), 32'(SEL_NONE));
            chk("tmo_ready", 32'(cmd_if.cmd_ready), 1);
         end else begin
            chk("done_pulse", 32'(done_o), 1);
            chk("done_select", 32'(select_o), 32'(sel));
            chk("done_err", 32'(err_o), 0);
         end
      end
      cmd_if.cmd_valid = 1'b0;
      if (!tmo_exit) begin
         busy    = '0;
         valid_i = 1'($urandom_range(0, 1));
         cyc();
         chk("idle_select", 32'(select_o), 32'(SEL_NONE));
         chk("idle_ready", 32'(cmd_if.cmd_ready), 1);
         chk("idle_done", 32'(done_o), 0);
         chk("idle_strobe", strobes(), 0);
      end
      busy    = '0;
      valid_i = 1'b0;
   endtask

   task automatic rand_beats();
      logic [7:0] c;
      int len;
      beats.delete();
      len = $urandom_range(0, 5);
      for (int i = 0; i < len; i++) begin
         if ($urandom_range(0, 2) == 0) beats.push_back({1'b0, 8'($urandom)});
         c = 8'($urandom_range(0, 255));
         if (c == ENDC) c = 8'h41;
         beats.push_back({1'b1, c});
      end
      if ($urandom_range(0, 2) == 0) beats.push_back({1'b0, ENDC});
      beats.push_back({1'b1, ENDC});
   endtask

   initial begin
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_sel   = 2'd0;

      rst_n = 1'b0;
      cyc();
      cyc();
      chk("rst_ready", 32'(cmd_if.cmd_ready), 1);
      chk("rst_select", 32'(select_o), 32'(SEL_NONE));
      chk("rst_data", 32'(data_o), 0);
      chk("rst_strobe", strobes(), 0);
      chk("rst_done", 32'(done_o), 0);
      chk("rst_err", 32'(err_o), 0);
      rst_n = 1'b1;
      cyc();

      beats.delete();
      beats.push_back({1'b1, 8'h41});
      beats.push_back({1'b1, 8'h42});
      beats.push_back({1'b1, ENDC});
      run_msg(SEL_CAESAR, 0);

      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_sel   = SEL_NONE;
      valid_i = 1'b1;
      data_i  = 8'h55;
      cyc();
      chk("ill_err", 32'(err_o), 1);
      chk("ill_ready", 32'(cmd_if.cmd_ready), 1);
      chk("ill_select", 32'(select_o), 32'(SEL_NONE));
      chk("idle_valid_drop", strobes(), 0);
      cmd_if.cmd_valid = 1'b0;
      valid_i = 1'b0;
      cyc();
      chk("ill_err_clear", 32'(err_o), 0);
      chk("ill_select2", 32'(select_o), 32'(SEL_NONE));

      beats.delete();
      beats.push_back({1'b1, 8'h10});
      beats.push_back({1'b1, ENDC});
      run_msg(SEL_ZIGZAG, 10);

      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_sel   = SEL_SCYTALE;
      cyc();
      cmd_if.cmd_valid = 1'b0;
      valid_i = 1'b1;
      data_i  = 8'h33;
      cyc();
      chk("mid_strobe", strobes(), 32'h2);
      rst_n = 1'b0;
      data_i = 8'h34;
      cyc();
      chk("mrst_select", 32'(select_o), 32'(SEL_NONE));
      chk("mrst_valid1", 32'(valid1_o), 0);
      chk("mrst_ready", 32'(cmd_if.cmd_ready), 1);
      chk("mrst_data", 32'(data_o), 0);
      rst_n = 1'b1;
      valid_i = 1'b0;
      cyc();

      beats.delete();
      beats.push_back({1'b1, 8'h61});
      beats.push_back({1'b1, ENDC});
`ifdef DEC_CTRL_TIMEOUT_EN
      run_msg(SEL_SCYTALE, 40);
      cyc();
      chk("tmo_err_clear", 32'(err_o), 0);
      chk("tmo_idle_ready", 32'(cmd_if.cmd_ready), 1);
`else
      run_msg(SEL_SCYTALE, 40);
`endif

      for (int m = 0; m < 30; m++) begin
         rand_beats();
         run_msg(2'($urandom_range(0, 2)), $urandom_range(0, 5));
         if ($urandom_range(0, 3) == 0) begin
            cmd_if.cmd_valid = 1'b1;
            cmd_if.cmd_sel   = SEL_NONE;
            cyc();
            chk("rnd_ill_err", 32'(err_o), 1);
            chk("rnd_ill_select", 32'(select_o), 32'(SEL_NONE));
            cmd_if.cmd_valid = 1'b0;
         end
      end

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
